// File: rtl/tx_loop.sv
// tx_loop: looping Manchester-coded VLC test frame transmitter driving DAC codes
module tx_loop #(
  parameter int WIDTH = 10,
  parameter int CLK_DIV = 8,
  parameter int PREAMBLE_BYTES = 4,
  parameter logic [7:0] SFD_BYTE = 8'hA7,
  parameter int PAYLOAD_LEN = 16,
  parameter int GAP_CHIPS = 64,
  parameter int FRAME_COUNT = 0,
  parameter logic [WIDTH-1:0] LEVEL_HIGH = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] LEVEL_LOW = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  output logic [WIDTH-1:0] o_tx_out,
  output logic             o_tx_out_clk,
  output logic             o_tx_sfd,
  output logic             o_tx_active,
  output logic [15:0]      o_frame_cnt,
  output logic             o_done
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, LEN, PAYLOAD, GAP, DONE} state_t;
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES * 16 - 1);
  localparam logic [15:0] PAY_LAST = 16'(PAYLOAD_LEN * 16 - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CHIPS - 1);
  localparam logic [15:0] FC = 16'(FRAME_COUNT);
  state_t state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [15:0] chip, chip_nxt, frame_cnt, cnt_nxt, sec_last;
  logic stop_lat, stop_nxt, stb, stb_nxt, wrap, last, active_nxt, chip_hi;
  logic [7:0] byte_val;
  logic [WIDTH-1:0] tx, tx_nxt;
  assign wrap = tmr == TMAX;
  assign sec_last = state == PREAMBLE ? PRE_LAST : state == PAYLOAD ? PAY_LAST : state == GAP ? GAP_LAST : 16'd15;
  assign last = chip == sec_last;
  assign active_nxt = state_nxt inside {PREAMBLE, SFD, LEN, PAYLOAD};
  assign byte_val = state_nxt == PREAMBLE ? 8'h55 :
                    state_nxt == SFD ? SFD_BYTE :
                    state_nxt == LEN ? 8'(PAYLOAD_LEN) :
                    state_nxt == PAYLOAD ? frame_cnt[7:0] + chip_nxt[11:4] : 8'h00;
  assign chip_hi = byte_val[~chip_nxt[3:1]] ^ chip_nxt[0];
  assign tx_nxt = active_nxt && chip_hi ? LEVEL_HIGH : LEVEL_LOW;
  // next state: chip timer, chip position within section, section sequencing and frame count
  always_comb begin
    state_nxt = state;
    tmr_nxt = tmr;
    chip_nxt = chip;
    cnt_nxt = frame_cnt;
    stb_nxt = 1'b0;
    stop_nxt = state == IDLE ? 1'b0 : stop_lat | i_stop;
    if (state == IDLE) begin
      if (i_start) begin
        state_nxt = PREAMBLE;
        tmr_nxt = '0;
        chip_nxt = '0;
        cnt_nxt = '0;
        stb_nxt = 1'b1;
      end
    end else if (state == DONE) begin
      state_nxt = IDLE;
    end else begin
      tmr_nxt = wrap ? '0 : tmr + TW'(1);
      if (wrap) begin
        chip_nxt = last ? 16'd0 : chip + 16'd1;
        if (last) begin
          state_nxt = state == PREAMBLE ? SFD :
                      state == SFD ? LEN :
                      state == LEN ? PAYLOAD :
                      state == PAYLOAD ? GAP :
                      (stop_lat || i_stop || (FC != 16'd0 && frame_cnt == FC)) ? DONE : PREAMBLE;
          cnt_nxt = state == PAYLOAD ? frame_cnt + 16'd1 : frame_cnt;
        end
        stb_nxt = state_nxt != DONE;
      end
    end
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tmr <= '0;
      chip <= '0;
      frame_cnt <= '0;
      stop_lat <= 1'b0;
      stb <= 1'b0;
      tx <= LEVEL_LOW;
    end else begin
      state <= state_nxt;
      tmr <= tmr_nxt;
      chip <= chip_nxt;
      frame_cnt <= cnt_nxt;
      stop_lat <= stop_nxt;
      stb <= stb_nxt;
      tx <= tx_nxt;
    end
  end
  assign o_tx_out = tx;
  assign o_tx_out_clk = stb;
  assign o_tx_active = state inside {PREAMBLE, SFD, LEN, PAYLOAD};
  assign o_tx_sfd = state inside {LEN, PAYLOAD};
  assign o_frame_cnt = frame_cnt;
  assign o_done = state == DONE;
endmodule

// File: tb/tb_tx_loop.sv
// tb_tx_loop: scoreboard bench decoding frames from two tx_loop configurations
module tb_tx_loop;
  logic clk = 1'b0;
  logic rst_n, start0, start1, stop1;
  logic [9:0] out0, out1;
  logic oclk0, oclk1, sfd0, sfd1, act0, act1, done0, done1;
  logic [15:0] cnt0, cnt1;
  int n_cmp = 0, n_bad = 0;
  int eb[$], ea[$], es[$], eg[$], ed[$], sa[$], ss[$], sd[$];
  always #5 clk = ~clk;
  tx_loop #(.FRAME_COUNT(2)) u0 (
    .clk(clk), .reset(rst_n), .i_start(start0), .i_stop(1'b0),
    .o_tx_out(out0), .o_tx_out_clk(oclk0), .o_tx_sfd(sfd0), .o_tx_active(act0),
    .o_frame_cnt(cnt0), .o_done(done0)
  );
  tx_loop #(.CLK_DIV(2), .PAYLOAD_LEN(1), .GAP_CHIPS(4), .FRAME_COUNT(0)) u1 (
    .clk(clk), .reset(rst_n), .i_start(start1), .i_stop(stop1),
    .o_tx_out(out1), .o_tx_out_clk(oclk1), .o_tx_sfd(sfd1), .o_tx_active(act1),
    .o_frame_cnt(cnt1), .o_done(done1)
  );
  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask
  function automatic logic sig(input int sel);
    return sel == 0 ? act0 : sel == 1 ? done0 : sel == 2 ? sfd0 : sel == 3 ? sfd1 : done1;
  endfunction
  task automatic wait_for(input int sel, input logic lvl, input int budget, input string name);
    int n = 0;
    while (sig(sel) != lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(sig(sel) == lvl), 1);
  endtask
  task automatic push_frame(input int f, input bit timing);
    for (int i = 0; i < 4; i++) eb.push_back(8'h55);
    eb.push_back(8'hA7);
    eb.push_back(16);
    for (int k = 0; k < 16; k++) eb.push_back((f + k) % 256);
    if (timing) begin
      ea.push_back(2816);
      es.push_back(2176);
      eg.push_back(512);
    end
  endtask
  // default-config monitor: byte decode, section lengths, done pulse
  initial begin
    int nchip = 0, nbit = 0, a_len = 0, s_len = 0, g_len = 0;
    logic first = 1'b0, in_gap = 1'b0, done_q = 1'b0;
    logic [7:0] acc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nchip = 0; nbit = 0; a_len = 0; s_len = 0; in_gap = 1'b0; done_q = 1'b0;
      end else begin
        if (oclk0 && act0) begin
          if (nchip % 2 == 0) first = out0 == 10'h3FF;
          else begin
            chk("manchester chip pair", int'(out0 == 10'h3FF), int'(!first));
            acc = {acc[6:0], first};
            nbit++;
            if (nbit == 8) begin
              chk("byte", int'(acc), eb.size() > 0 ? eb.pop_front() : -1);
              nbit = 0;
            end
          end
          nchip++;
        end else if (!act0) begin
          nchip = 0;
          nbit = 0;
        end
        if (act0) begin
          if (in_gap) begin
            chk("gap cycles", g_len, eg.size() > 0 ? eg.pop_front() : -1);
            in_gap = 1'b0;
          end
          a_len++;
        end else if (a_len > 0) begin
          chk("active cycles", a_len, ea.size() > 0 ? ea.pop_front() : -1);
          a_len = 0;
          in_gap = 1'b1;
          g_len = 1;
        end else if (in_gap && !done0) g_len++;
        else if (in_gap) begin
          chk("gap cycles", g_len, eg.size() > 0 ? eg.pop_front() : -1);
          in_gap = 1'b0;
        end
        if (sfd0) s_len++;
        else if (s_len > 0) begin
          chk("sfd cycles", s_len, es.size() > 0 ? es.pop_front() : -1);
          s_len = 0;
        end
        if (done_q) chk("done width", int'(done0), 0);
        if (done0) chk("done frame count", int'(cnt0), ed.size() > 0 ? ed.pop_front() : -1);
        done_q = done0;
      end
    end
  end
  // small-config monitor: strobe period, frame/sfd lengths, frame count at done
  initial begin
    int cyc = 0, last1 = -1, a1 = 0, s1 = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        last1 = -1; a1 = 0; s1 = 0;
      end else begin
        if (oclk1) begin
          if (last1 >= 0) chk("strobe period", cyc - last1, 2);
          last1 = cyc;
        end
        if (done1) begin
          chk("stop frame count", int'(cnt1), sd.size() > 0 ? sd.pop_front() : -1);
          last1 = -1;
        end
        if (act1) a1++;
        else if (a1 > 0) begin
          chk("small frame cycles", a1, sa.size() > 0 ? sa.pop_front() : -1);
          a1 = 0;
        end
        if (sfd1) s1++;
        else if (s1 > 0) begin
          chk("small sfd cycles", s1, ss.size() > 0 ? ss.pop_front() : -1);
          s1 = 0;
        end
      end
    end
  end
  // stimulus
  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; stop1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", int'(out0), 0);
    chk("reset strobe", int'(oclk0), 0);
    chk("reset active", int'(act0), 0);
    chk("reset sfd", int'(sfd0), 0);
    chk("reset done", int'(done0), 0);
    chk("reset count", int'(cnt0), 0);
    chk("reset small active", int'(act1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(0, 1); push_frame(1, 1); ed.push_back(2);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    wait_for(0, 1'b0, 4000, "frame 1 end timeout");
    chk("count after frame 1", int'(cnt0), 1);
    wait_for(1, 1'b1, 8000, "run A done timeout");
    push_frame(0, 1); push_frame(1, 1); ed.push_back(2);
    start0 = 1'b1;
    @(negedge clk);
    chk("idle after done active", int'(act0), 0);
    chk("idle holds count", int'(cnt0), 2);
    @(negedge clk);
    chk("restart active", int'(act0), 1);
    chk("restart count cleared", int'(cnt0), 0);
    chk("restart strobe", int'(oclk0), 1);
    wait_for(1, 1'b1, 8000, "run B done timeout");
    push_frame(0, 0);
    @(negedge clk);
    chk("held start idle", int'(act0), 0);
    @(negedge clk);
    chk("held start restart", int'(act0), 1);
    start0 = 1'b0;
    wait_for(2, 1'b1, 4000, "run C sfd timeout");
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out", int'(out0), 0);
    chk("async reset active", int'(act0), 0);
    chk("async reset sfd", int'(sfd0), 0);
    chk("async reset done", int'(done0), 0);
    chk("async reset count", int'(cnt0), 0);
    eb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle after reset active", int'(act0), 0);
    chk("idle after reset out", int'(out0), 0);
    for (int i = 0; i < 3; i++) begin
      sa.push_back(224);
      ss.push_back(64);
    end
    sd.push_back(3);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    wait_for(3, 1'b1, 500, "small f1 sfd timeout");
    wait_for(3, 1'b0, 500, "small f1 end timeout");
    wait_for(3, 1'b1, 500, "small f2 sfd timeout");
    wait_for(3, 1'b0, 500, "small f2 end timeout");
    wait_for(3, 1'b1, 500, "small f3 sfd timeout");
    repeat (40) @(negedge clk);
    stop1 = 1'b1;
    @(negedge clk); stop1 = 1'b0;
    wait_for(4, 1'b1, 1000, "stop done timeout");
    repeat (100) @(negedge clk);
    chk("no frame after stop", int'(act1), 0);
    chk("count holds after stop", int'(cnt1), 3);
    chk("bytes left", eb.size(), 0);
    chk("expectations left", ea.size() + es.size() + eg.size() + ed.size() + sa.size() + ss.size() + sd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
